tristate_bus_ctrl: RTL and testbench

- Parametrised multi-channel tristate bus controller; successor to the single-enable tristate buffer.
- N requesters share one W-bit bidirectional bus.
- Round-robin arbitration, a registered output enable, bounded burst length and an enforced all-Z turnaround between owners, so no two drivers are ever enabled in the same cycle.
- Sits between on-chip masters and a shared inout bus/pad group.

---
 rtl/tristate_bus_ctrl_pkg.sv | 19 +
 rtl/tristate_bus_ctrl_if.sv | 23 ++
 rtl/tristate_bus_ctrl_rr_arbiter.sv | 33 +++
 rtl/tristate_bus_ctrl.sv | 101 ++++++++++
 tb/tb_tristate_bus_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/tristate_bus_ctrl_pkg.sv
// Shared state encodings, counter widths and helpers for tristate_bus_ctrl.
// Optional bus-keeper behaviour is enabled with TRISTATE_KEEPER_EN.
package tristate_bus_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    localparam int BCW = 8;
    localparam int TCW = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/tristate_bus_ctrl_if.sv
// Request/grant/status bundle between on-chip masters and tristate_bus_ctrl.
// The shared pad net itself stays a plain inout on the controller.
interface tristate_bus_ctrl_if #(
    parameter int W = 4,
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic           oe;
    logic [W-1:0]   rdata;
    logic           busy;

    modport master (
        output req, wdata,
        input  gnt, oe, rdata, busy
    );

    modport slave (
        input  req, wdata,
        output gnt, oe, rdata, busy
    );
endinterface

// File: rtl/tristate_bus_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first set req above ptr, wrapping.
// Returns both a one-hot grant and the winning index.
module rr_arbiter
    import tristate_bus_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic found;
    int   c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 1; i <= N; i++) begin
            c = (int'(ptr) + i) % N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = PW'(c);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_ctrl.sv
// N-channel round-robin tristate bus controller with burst cap and turnaround.
// Define TRISTATE_KEEPER_EN to make rdata hold the last driven value.
module tristate_bus_ctrl
    import tristate_bus_ctrl_pkg::*;
#(
    parameter int W         = 4,
    parameter int N         = 4,
    parameter int MAX_BURST = 8,
    parameter int TURN_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    tristate_bus_ctrl_if.slave   bif,
    inout  wire  [W-1:0]         bus
);

    localparam int PW = (N > 1) ? clog2(N) : 1;

    logic [1:0]     state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  aidx;
    logic [N-1:0]   agnt;
    logic [N-1:0]   gnt;
    logic           oe;
    logic [BCW-1:0] bcnt;
    logic [TCW-1:0] tcnt;
    logic [W-1:0]   rdata;
    logic           rel;

    rr_arbiter #(.N(N), .PW(PW)) u_arb (
        .req (bif.req),
        .ptr (ptr),
        .gnt (agnt),
        .idx (aidx)
    );

    // ptr doubles as the owner index while driving
    assign rel = !bif.req[ptr] || (bcnt == BCW'(MAX_BURST));
    assign bus = oe ? bif.wdata[ptr*W +: W] : {W{1'bz}};

    assign bif.gnt   = gnt;
    assign bif.oe    = oe;
    assign bif.rdata = rdata;
    assign bif.busy  = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
            oe    <= 1'b0;
            ptr   <= PW'(N - 1);
            bcnt  <= '0;
            tcnt  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|bif.req) begin
                        gnt   <= agnt;
                        oe    <= 1'b1;
                        ptr   <= aidx;
                        bcnt  <= BCW'(1);
                        state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (rel) begin
                        gnt   <= '0;
                        oe    <= 1'b0;
                        bcnt  <= '0;
                        tcnt  <= TCW'(1);
                        state <= (TURN_CYC > 0) ? ST_TURN : ST_IDLE;
                    end else begin
                        bcnt <= bcnt + BCW'(1);
                    end
                end
                ST_TURN: begin
                    if (tcnt == TCW'(TURN_CYC)) begin
                        tcnt  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + TCW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
`ifdef TRISTATE_KEEPER_EN
            if (oe) rdata <= bus;
`else
            rdata <= bus;
`endif
        end
    end

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Self-checking bench for tristate_bus_ctrl: ownership model plus directed cases.
// Honours TRISTATE_KEEPER_EN the same way as the design.
module tb_tristate_bus_ctrl;

    localparam int W         = 4;
    localparam int N         = 4;
    localparam int MAX_BURST = 8;
    localparam int TURN_CYC  = 1;
    localparam logic [N*W-1:0] D = 16'hAE51;

    logic clk = 1'b0;
    logic rst;
    wire  [W-1:0] bus;

    tristate_bus_ctrl_if #(.W(W), .N(N)) bif ();

    tristate_bus_ctrl #(
        .W(W), .N(N), .MAX_BURST(MAX_BURST), .TURN_CYC(TURN_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Ownership model: who owns the bus, how long, Z cycles still owed
    int mcur  = -1;
    int mrun  = 0;
    int mz    = 0;
    int mlast = N - 1;
    logic [W-1:0] mrd = '0;
    bit mrd_ok = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mrd = '0; mrd_ok = 1'b1;
            mcur = -1; mrun = 0; mz = 0; mlast = N - 1;
        end else begin
            if (mcur >= 0) begin
                mrd = bif.wdata[mcur*W +: W]; mrd_ok = 1'b1;
            end else begin
`ifndef TRISTATE_KEEPER_EN
                mrd_ok = 1'b0;
`endif
            end
            if (mcur >= 0) begin
                if (!bif.req[mcur] || mrun == MAX_BURST) begin
                    mcur = -1; mz = TURN_CYC;
                end else mrun++;
            end else if (mz > 0) begin
                mz--;
            end else if (bif.req != 0) begin
                mcur = pick(bif.req, mlast); mlast = mcur; mrun = 1;
            end
        end
    end

    // Grant log and per-channel drive-cycle counts, from DUT outputs
    int cyc = 0;
    logic [N-1:0] glog[$];
    int gcyc[$];
    logic [N-1:0] prevg = '0;
    int dcnt[N];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (en) begin
            eg = (mcur >= 0) ? (N'(1) << mcur) : '0;
            chk("gnt", 32'(bif.gnt), 32'(eg));
            chk("oe", 32'(bif.oe), 32'(mcur >= 0));
            chk("busy", 32'(bif.busy), 32'(mcur >= 0 || mz > 0));
            if (mcur >= 0)
                chk("bus", 32'(bus), 32'(bif.wdata[mcur*W +: W]));
            if (mrd_ok)
                chk("rdata", 32'(bif.rdata), 32'(mrd));
        end
        if (bif.gnt != 0 && bif.gnt != prevg) begin
            glog.push_back(bif.gnt);
            gcyc.push_back(cyc);
        end
        prevg = bif.gnt;
        for (int i = 0; i < N; i++)
            if (bif.oe && bif.gnt[i]) dcnt[i]++;
    end

    task automatic drive(input logic rs, input logic [N-1:0] r,
                         input logic [N*W-1:0] d, input int n);
        rst = rs; bif.req = r; bif.wdata = d;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clr();
        glog.delete();
        gcyc.delete();
        for (int i = 0; i < N; i++) dcnt[i] = 0;
    endtask

    initial begin
        logic [N-1:0] rr_exp[5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; bif.req = '1; bif.wdata = D;
        @(posedge clk);
        #2;
        en = 1'b1;
        drive(1'b1, 4'b1111, D, 1);
        chk("rst_gnt", 32'(bif.gnt), 32'h0);
        chk("rst_oe", 32'(bif.oe), 32'h0);
        chk("rst_busy", 32'(bif.busy), 32'h0);
        chk("rst_rdata", 32'(bif.rdata), 32'h0);

        clr();
        drive(1'b0, 4'b1111, D, 1);
        chk("first_gnt", 32'(bif.gnt), 32'h1);
        chk("first_bus", 32'(bus), 32'h1);
        chk("model_first", 32'(mcur), 32'h0);
        drive(1'b0, 4'b1111, D, 49);
        drive(1'b0, 4'b0000, D, 3);
        chk("rr_count", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order%0d", i), 32'(glog[i]), 32'(rr_exp[i]));

        clr();
        drive(1'b0, 4'b1010, D, 20);
        drive(1'b0, 4'b0000, D, 3);
        chk("cap_first", 32'(glog[0]), 32'b0010);
        chk("cap_next", 32'(glog[1]), 32'b1000);
        chk("cap_len", 32'(dcnt[1]), 32'd8);
        chk("cap_gap", 32'(gcyc[1] - gcyc[0]), 32'd10);

        clr();
        drive(1'b0, 4'b0100, D, 1);
        chk("single_bus", 32'(bus), 32'hE);
        chk("single_busy", 32'(bif.busy), 32'h1);
        drive(1'b0, 4'b0100, D, 2);
        drive(1'b0, 4'b0000, D, 1);
        chk("turn_oe", 32'(bif.oe), 32'h0);
        chk("turn_busy", 32'(bif.busy), 32'h1);
        chk("single_len", 32'(dcnt[2]), 32'd3);
        chk("single_rd", 32'(bif.rdata), 32'hE);
        drive(1'b0, 4'b0000, D, 1);
        chk("idle_busy", 32'(bif.busy), 32'h0);
`ifdef TRISTATE_KEEPER_EN
        drive(1'b0, 4'b0000, D, 1);
        chk("keep_rd", 32'(bif.rdata), 32'hE);
`endif

        drive(1'b0, 4'b0001, D, 3);
        chk("md_oe", 32'(bif.oe), 32'h1);
        chk("md_gnt", 32'(bif.gnt), 32'h1);
        drive(1'b1, 4'b0011, D, 1);
        chk("md_rst_oe", 32'(bif.oe), 32'h0);
        chk("md_rst_gnt", 32'(bif.gnt), 32'h0);
        chk("md_rst_busy", 32'(bif.busy), 32'h0);
        drive(1'b0, 4'b0011, D, 1);
        chk("md_ch0", 32'(bif.gnt), 32'h1);
        drive(1'b0, 4'b0000, D, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1);
    end

endmodule
